// File: rtl/edu_token_row_tracker.sv
// Token-row pending mask for the setup stage: inserts set a row bit, releases clear it.
// Counts occupancy, pulses error flags and runs a one-cycle flush.
module edu_token_row_tracker #(
    parameter int NUM_TKROW  = 10,
    parameter int ROWADDR_BW = 4,
    parameter int CNT_BW     = ROWADDR_BW + 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ins_valid,
    input  logic [ROWADDR_BW-1:0] ins_row,
    output logic                  ins_ready,
    input  logic                  rel_valid,
    input  logic [ROWADDR_BW-1:0] rel_row,
    input  logic                  flush_req,
    output logic [NUM_TKROW-1:0]  token_exist_rows_0_reg,
    output logic [CNT_BW-1:0]     token_cnt,
    output logic                  all_empty,
    output logic                  busy,
    output logic                  dup_err,
    output logic                  oob_err,
    output logic                  rel_err
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        FLUSH  = 2'd2
    } state_t;

    state_t                 state_reg, state_next;
    logic [NUM_TKROW-1:0]   mask_reg, mask_next;
    logic [CNT_BW-1:0]      cnt_reg, cnt_next;
    logic                   empty_reg;
    logic                   dup_reg, oob_reg, rel_err_reg;
    logic                   dup_next, oob_next, rel_err_next;

    logic [NUM_TKROW-1:0]   ins_sel, rel_sel, ins_oh, rel_oh, kept;
    logic                   ins_acc, rel_gate, flush_cmd;

    // Row selectors only exist for in-range addresses, so an empty selector means out of range
    generate
        for (genvar gi = 0; gi < NUM_TKROW; gi++) begin : g_decode
            assign ins_sel[gi] = (ins_row == ROWADDR_BW'(gi));
            assign rel_sel[gi] = (rel_row == ROWADDR_BW'(gi));
        end
    endgenerate

    assign flush_cmd = flush_req & (state_reg != FLUSH);
    assign ins_acc   = ins_valid & ins_ready;
    assign rel_gate  = rel_valid & (state_reg != FLUSH) & ~flush_req;
    assign ins_oh    = {NUM_TKROW{ins_acc}} & ins_sel;
    assign rel_oh    = {NUM_TKROW{rel_gate}} & rel_sel & mask_reg;
    assign kept      = mask_reg & ~rel_oh;

    always_comb begin
        mask_next = kept | ins_oh;
        if (flush_cmd) begin
            mask_next = '0;
        end
    end

    always_comb begin
        cnt_next = '0;
        for (int i = 0; i < NUM_TKROW; i++) begin
            cnt_next = cnt_next + CNT_BW'(mask_next[i]);
        end
    end

    assign dup_next     = |(ins_oh & kept);
    assign oob_next     = (ins_acc & ~|ins_sel) | (rel_valid & ~|rel_sel);
    assign rel_err_next = rel_gate & (|rel_sel) & ~|(rel_sel & mask_reg);

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE, ACTIVE: begin
                if (flush_req) begin
                    state_next = FLUSH;
                end else if (mask_next != '0) begin
                    state_next = ACTIVE;
                end else begin
                    state_next = IDLE;
                end
            end
            FLUSH:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        ins_ready = (state_reg != FLUSH) & ~flush_req;
        busy      = (state_reg == FLUSH);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mask_reg    <= '0;
            cnt_reg     <= '0;
            empty_reg   <= 1'b1;
            dup_reg     <= 1'b0;
            oob_reg     <= 1'b0;
            rel_err_reg <= 1'b0;
        end else begin
            mask_reg    <= mask_next;
            cnt_reg     <= cnt_next;
            empty_reg   <= (mask_next == '0);
            dup_reg     <= dup_next;
            oob_reg     <= oob_next;
            rel_err_reg <= rel_err_next;
        end
    end

    assign token_exist_rows_0_reg = mask_reg;
    assign token_cnt              = cnt_reg;
    assign all_empty              = empty_reg;
    assign dup_err                = dup_reg;
    assign oob_err                = oob_reg;
    assign rel_err                = rel_err_reg;

endmodule

// File: tb/tb_edu_token_row_tracker.sv
// Directed scoreboard bench: stimulus queues expected outputs, monitor compares each cycle.
module tb_edu_token_row_tracker;

    localparam int N  = 10;
    localparam int AW = 4;
    localparam int CW = AW + 1;

    logic          clk = 1'b0;
    logic          rst_n, ins_valid, rel_valid, flush_req;
    logic [AW-1:0] ins_row, rel_row;
    logic          ins_ready, all_empty, busy, dup_err, oob_err, rel_err;
    logic [N-1:0]  mask;
    logic [CW-1:0] token_cnt;

    edu_token_row_tracker #(.NUM_TKROW(N), .ROWADDR_BW(AW), .CNT_BW(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .ins_valid(ins_valid), .ins_row(ins_row), .ins_ready(ins_ready),
        .rel_valid(rel_valid), .rel_row(rel_row), .flush_req(flush_req),
        .token_exist_rows_0_reg(mask), .token_cnt(token_cnt), .all_empty(all_empty),
        .busy(busy), .dup_err(dup_err), .oob_err(oob_err), .rel_err(rel_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int           id;
        logic [N-1:0] mask;
        int           cnt;
        logic         empty, busy, dup, oob, rel;
        int           rdy;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   vec_id = 0;

    task automatic chk(input string nm, input int id, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL vec %0d %s: got 0x%0h expected 0x%0h", id, nm, act, exp);
        end
    endtask

    // Monitor: ready is sampled mid-cycle with the stimulus applied, registered outputs after the edge
    initial begin
        logic rdy_s;
        exp_t e;
        forever begin
            @(negedge clk);
            #3;
            rdy_s = ins_ready;
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                if (e.rdy >= 0) chk("ins_ready", e.id, 32'(rdy_s), 32'(e.rdy));
                chk("mask", e.id, 32'(mask), 32'(e.mask));
                chk("token_cnt", e.id, 32'(token_cnt), 32'(e.cnt));
                chk("all_empty", e.id, 32'(all_empty), 32'(e.empty));
                chk("busy", e.id, 32'(busy), 32'(e.busy));
                chk("errs", e.id, {29'd0, dup_err, oob_err, rel_err}, {29'd0, e.dup, e.oob, e.rel});
                $display("vec %0d: mask=0x%03h cnt=%0d empty=%0b busy=%0b dup/oob/rel=%0b%0b%0b rdy=%0b",
                         e.id, mask, token_cnt, all_empty, busy, dup_err, oob_err, rel_err, rdy_s);
            end
        end
    end

    task automatic cyc(input logic rst, input logic iv, input int ir, input logic rv, input int rr,
                       input logic fl, input logic [N-1:0] m, input logic b, input logic d,
                       input logic o, input logic r, input int rdy);
        exp_t e;
        @(negedge clk);
        rst_n     = rst;
        ins_valid = iv;
        ins_row   = AW'(ir);
        rel_valid = rv;
        rel_row   = AW'(rr);
        flush_req = fl;
        e.id    = vec_id;
        e.mask  = m;
        e.cnt   = $countones(m);
        e.empty = (m == '0);
        e.busy  = b;
        e.dup   = d;
        e.oob   = o;
        e.rel   = r;
        e.rdy   = rdy;
        q.push_back(e);
        vec_id++;
    endtask

    initial begin
        logic [N-1:0] fill;
        rst_n = 1'b0; ins_valid = 1'b0; ins_row = '0;
        rel_valid = 1'b0; rel_row = '0; flush_req = 1'b0;

        // Reset with an insert pending
        cyc(0, 1, 3, 0, 0, 0, 10'h000, 0, 0, 0, 0, -1);
        cyc(0, 1, 3, 0, 0, 0, 10'h000, 0, 0, 0, 0, 1);

        // Inserts 2, 0, 5 then release 0
        cyc(1, 1, 2, 0, 0, 0, 10'h004, 0, 0, 0, 0, 1);
        cyc(1, 1, 0, 0, 0, 0, 10'h005, 0, 0, 0, 0, 1);
        cyc(1, 1, 5, 0, 0, 0, 10'h025, 0, 0, 0, 0, 1);
        cyc(1, 0, 0, 1, 0, 0, 10'h024, 0, 0, 0, 0, 1);
        cyc(1, 0, 0, 1, 5, 0, 10'h004, 0, 0, 0, 0, 1);

        // Same-row release+insert keeps the bit, then a lone duplicate insert
        cyc(1, 1, 2, 1, 2, 0, 10'h004, 0, 0, 0, 0, 1);
        cyc(1, 1, 2, 0, 0, 0, 10'h004, 0, 1, 0, 0, 1);

        // Different rows in one cycle
        cyc(1, 1, 3, 1, 2, 0, 10'h008, 0, 0, 0, 0, 1);
        cyc(1, 1, 2, 1, 3, 0, 10'h004, 0, 0, 0, 0, 1);

        // Out-of-range insert and release, then release of a clear row
        cyc(1, 1, N, 1, N + 1, 0, 10'h004, 0, 0, 1, 0, 1);
        cyc(1, 0, 0, 1, 1, 0, 10'h004, 0, 0, 0, 1, 1);

        // Fill every row, then one more insert while full
        fill = 10'h004;
        for (int r = 0; r < N; r++) begin
            if (r != 2) begin
                fill = fill | (N'(1) << r);
                cyc(1, 1, r, 0, 0, 0, fill, 0, 0, 0, 0, 1);
            end
        end
        cyc(1, 1, 5, 0, 0, 0, 10'h3FF, 0, 1, 0, 0, 1);

        // Flush with a concurrent insert and release, then requests during FLUSH
        cyc(1, 1, 0, 1, 1, 1, 10'h000, 1, 0, 0, 0, 0);
        cyc(1, 1, 3, 1, 3, 1, 10'h000, 0, 0, 0, 0, 0);
        cyc(1, 1, 3, 0, 0, 0, 10'h008, 0, 0, 0, 0, 1);

        // Reset while in FLUSH
        cyc(1, 0, 0, 0, 0, 1, 10'h000, 1, 0, 0, 0, 0);
        cyc(0, 1, 5, 0, 0, 0, 10'h000, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 10'h000, 0, 0, 0, 0, 1);

        // Setup-stage loopback: lowest pending row released each cycle
        cyc(1, 1, 4, 0, 0, 0, 10'h010, 0, 0, 0, 0, 1);
        cyc(1, 1, 1, 0, 0, 0, 10'h012, 0, 0, 0, 0, 1);
        cyc(1, 1, 7, 0, 0, 0, 10'h092, 0, 0, 0, 0, 1);
        cyc(1, 0, 0, 1, 1, 0, 10'h090, 0, 0, 0, 0, 1);
        cyc(1, 0, 0, 1, 4, 0, 10'h080, 0, 0, 0, 0, 1);
        cyc(1, 0, 0, 1, 7, 0, 10'h000, 0, 0, 0, 0, 1);

        @(negedge clk);
        ins_valid = 1'b0; rel_valid = 1'b0; flush_req = 1'b0;
        for (int k = 0; k < 20 && q.size() != 0; k++) @(posedge clk);
        #5;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expected responses left, required 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
